// File: rtl/oam_dma_engine.sv
// oam_dma_engine: OAM DMA controller.
// A CPU write to DMA_REG_ADDR (committed at t_cycle==11) latches the source
// page and starts a LEN-byte copy from {eff_hi, 8'h00} into OAM, one byte per
// M-cycle, after a one-M-cycle SETUP gap. The copy is read over the main memory
// bus and written out through a dedicated OAM write port.
// Optional build macro: DMA_ECHO_REMAP_EN maps source pages 0xE0..0xFF down by
// 0x20 onto work RAM (echo mirror). When it is undefined the page is used as-is.
//
// Handshake note: there is no valid/ready pair here. A register write is
// accepted unconditionally on the clk edge where t_cycle==11, cpu_wr==1 and
// cpu_addr==DMA_REG_ADDR, from any state. An accepted write during a copy
// restarts it. oam_wr is a one-clk strobe; the receiver must always accept it.
module oam_dma_engine #(
    parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
    parameter int          LEN          = 160
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  t_cycle,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data,
    input  logic        cpu_wr,
    output logic [7:0]  reg_rd_data,
    input  logic [7:0]  mem_data_in,
    output logic [15:0] dma_addr,
    output logic        dma_rd,
    output logic        dma_active,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_data,
    output logic        oam_wr,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(LEN - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] idx;
    logic [7:0] idx_next;
    logic [7:0] src_hi;
    logic [7:0] eff_hi;
    logic [7:0] byte_latch;
    logic       commit;
    logic       m_end;

    assign commit    = (t_cycle == 2'b11) && cpu_wr && (cpu_addr == DMA_REG_ADDR);
    assign m_end     = (t_cycle == 2'b11);
    assign dbg_state = state;

`ifdef DMA_ECHO_REMAP_EN
    // Echo RAM pages (0xE0..0xFF) alias work RAM 0x20 pages lower.
    assign eff_hi = (src_hi >= 8'hE0) ? (src_hi - 8'h20) : src_hi;
`else
    assign eff_hi = src_hi;
`endif

    // State, byte index and source register; a commit always wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            idx         <= 8'h00;
            src_hi      <= 8'h00;
            reg_rd_data <= 8'h00;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            if (commit) begin
                src_hi      <= cpu_data;
                reg_rd_data <= cpu_data;
            end
        end
    end

    // Source byte is captured at the end of the second T-state of each XFER M-cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_latch <= 8'h00;
        end else if ((state == XFER) && (t_cycle == 2'b01)) begin
            byte_latch <= mem_data_in;
        end
    end

    // Next-state logic and bus/OAM outputs decoded from registered state.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        dma_addr   = 16'h0000;
        dma_rd     = 1'b0;
        dma_active = 1'b0;
        oam_addr   = 8'h00;
        oam_data   = 8'h00;
        oam_wr     = 1'b0;

        case (state)
            IDLE: begin
                state_next = IDLE;
            end
            SETUP: begin
                if (m_end) begin
                    state_next = XFER;
                    idx_next   = 8'h00;
                end
            end
            XFER: begin
                dma_active = 1'b1;
                dma_addr   = {eff_hi, idx};
                dma_rd     = (t_cycle == 2'b00) || (t_cycle == 2'b01);
                oam_addr   = idx;
                oam_data   = byte_latch;
                oam_wr     = m_end;
                if (m_end) begin
                    if (idx == LAST_IDX) begin
                        state_next = IDLE;
                    end else begin
                        idx_next = idx + 8'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A register write restarts from SETUP, even on the final XFER write.
        if (commit) begin
            state_next = SETUP;
            idx_next   = 8'h00;
        end
    end

endmodule

// File: tb/tb_oam_dma_engine.sv
// Testbench for oam_dma_engine: table-driven full transfers plus directed
// sequences for reset mid-copy, address generation, restart and last-byte commit.
module tb_oam_dma_engine;

    localparam logic [15:0] DMA_REG = 16'hFF46;
`ifdef DMA_ECHO_REMAP_EN
    localparam bit ECHO = 1'b1;
`else
    localparam bit ECHO = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  t_cycle = 2'b00;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_data = 8'h00;
    logic        cpu_wr = 1'b0;
    logic [7:0]  reg_rd_data;
    logic [7:0]  mem_data_in;
    logic [15:0] dma_addr;
    logic        dma_rd;
    logic        dma_active;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_data;
    logic        oam_wr;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    // T-state counter advances once per clk, shortly after the rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1 t_cycle = t_cycle + 2'd1;
        end
    end

    oam_dma_engine dut (
        .clk         (clk),
        .rst         (rst),
        .t_cycle     (t_cycle),
        .cpu_addr    (cpu_addr),
        .cpu_data    (cpu_data),
        .cpu_wr      (cpu_wr),
        .reg_rd_data (reg_rd_data),
        .mem_data_in (mem_data_in),
        .dma_addr    (dma_addr),
        .dma_rd      (dma_rd),
        .dma_active  (dma_active),
        .oam_addr    (oam_addr),
        .oam_data    (oam_data),
        .oam_wr      (oam_wr),
        .dbg_state   (dbg_state)
    );

    // ---------------- memory model ----------------
    // C0 page holds i^5A; other pages are offset by their distance from C0.
    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ 8'h5A ^ (a[15:8] - 8'hC0);
    endfunction

    assign mem_data_in = dma_rd ? mem_byte(dma_addr) : 8'h00;

    // ---------------- scoreboard ----------------
    int         errors = 0;
    int         checks = 0;
    logic [7:0] oam [256];
    int         oam_pulses = 0;
    int         active_clks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // OAM write monitor: records writes and checks the strobe lands on t==11.
    always @(negedge clk) begin
        if (oam_wr === 1'b1) begin
            oam[oam_addr] = oam_data;
            oam_pulses++;
            checks++;
            if (t_cycle !== 2'b11) begin
                errors++;
                $display("FAIL oam_wr_phase: got t_cycle %b expected 11", t_cycle);
            end
        end
        if (dma_active === 1'b1) active_clks++;
    end

    // ---------------- driver tasks ----------------
    // Present a write during the t==11 clk so it commits on the following edge.
    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (t_cycle !== 2'b11 && n < 8);
        cpu_addr = a;
        cpu_data = d;
        cpu_wr   = 1'b1;
        @(posedge clk);
        #2;
        cpu_wr   = 1'b0;
        cpu_addr = 16'h0000;
        cpu_data = 8'h00;
    endtask

    task automatic clear_counts();
        oam_pulses  = 0;
        active_clks = 0;
    endtask

    // Four quiet SETUP clks, then the first XFER clk reads {hi,00}.
    task automatic check_setup_and_first(input logic [7:0] exp_hi);
        repeat (4) begin
            @(negedge clk);
            check("setup_quiet", {61'd0, dma_active, dma_rd, oam_wr}, 64'd0);
        end
        @(negedge clk);
        check("first_addr", {48'd0, dma_addr}, {48'd0, exp_hi, 8'h00});
        check("first_active_rd", {62'd0, dma_active, dma_rd}, 64'd3);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (dma_active === 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("done_in_time", {63'd0, (n < 1000)}, 64'd1);
        #1;
    endtask

    task automatic check_page(input string name, input logic [7:0] hi, input int first, input int last);
        int bad;
        bad = 0;
        for (int i = first; i <= last; i++) begin
            if (oam[i] !== mem_byte({hi, 8'(i)})) bad++;
        end
        check(name, 64'(bad), 64'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] src;
        logic [7:0] exp_hi;
    } vec_t;

    vec_t vecs [5];

    initial begin
        vecs[0] = '{src: 8'hC0, exp_hi: 8'hC0};
        vecs[1] = '{src: 8'h80, exp_hi: 8'h80};
        vecs[2] = '{src: 8'hE3, exp_hi: ECHO ? 8'hC3 : 8'hE3};
        vecs[3] = '{src: 8'hFF, exp_hi: ECHO ? 8'hDF : 8'hFF};
        vecs[4] = '{src: 8'h12, exp_hi: 8'h12};

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {19'd0, reg_rd_data, dma_addr, dma_rd, dma_active, oam_addr, oam_data, oam_wr, dbg_state},
              64'd0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Table-driven full transfers.
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < 256; i++) oam[i] = 8'hEE;
            cpu_write(DMA_REG, vecs[v].src);
            clear_counts();
            check_setup_and_first(vecs[v].exp_hi);
            wait_done();
            check("oam_pulses", 64'(oam_pulses), 64'd160);
            check("active_clks", 64'(active_clks), 64'd640);
            check("reg_rd_data", {56'd0, reg_rd_data}, {56'd0, vecs[v].src});
            check_page("oam_contents", vecs[v].exp_hi, 0, 159);
            check("oam_untouched_160", {56'd0, oam[160]}, 64'hEE);
        end

        // Writes to other addresses are ignored.
        cpu_write(16'hFF47, 8'hC0);
        repeat (8) begin
            @(negedge clk);
            check("ignore_other_addr", {61'd0, dma_active, dma_rd, oam_wr}, 64'd0);
        end
        check("ignore_keeps_reg", {56'd0, reg_rd_data}, 64'h12);

        // Address generation at XFER M-cycle 5.
        cpu_write(DMA_REG, 8'h80);
        repeat (24) @(negedge clk);
        @(negedge clk);
        check("m5_t0", {47'd0, dma_addr, dma_rd}, {47'd0, 16'h8005, 1'b1});
        @(negedge clk);
        check("m5_t1", {47'd0, dma_addr, dma_rd}, {47'd0, 16'h8005, 1'b1});
        @(negedge clk);
        check("m5_t2", {63'd0, dma_rd}, 64'd0);
        @(negedge clk);
        check("m5_t3", {47'd0, oam_wr, oam_addr, oam_data}, {47'd0, 1'b1, 8'h05, mem_byte(16'h8005)});
        wait_done();

        // Reset mid-transfer at idx 37.
        cpu_write(DMA_REG, 8'hC0);
        clear_counts();
        repeat (4 + 148) @(negedge clk);
        @(negedge clk);
        check("pre_reset_pulses", 64'(oam_pulses), 64'd37);
        check("pre_reset_idx37", {56'd0, dma_addr[7:0]}, 64'd37);
        rst = 1'b0;
        #1;
        check("reset_mid_xfer",
              {19'd0, reg_rd_data, dma_addr, dma_rd, dma_active, oam_addr, oam_data, oam_wr, dbg_state},
              64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        clear_counts();
        repeat (20) @(negedge clk);
        check("post_reset_pulses", 64'(oam_pulses), 64'd0);
        check("post_reset_active", 64'(active_clks), 64'd0);
        check("post_reset_idle", {62'd0, dbg_state}, 64'd0);

        // Restart at idx 10 with a new page.
        for (int i = 0; i < 256; i++) oam[i] = 8'hEE;
        cpu_write(DMA_REG, 8'hC0);
        clear_counts();
        repeat (4 + 40) @(negedge clk);
        cpu_write(DMA_REG, 8'hD0);
        #1;
        check("restart_pulses", 64'(oam_pulses), 64'd11);
        check_page("restart_old_c0", 8'hC0, 0, 10);
        check("restart_untouched_11", {56'd0, oam[11]}, 64'hEE);
        check("restart_reg", {56'd0, reg_rd_data}, 64'hD0);
        check_setup_and_first(8'hD0);
        wait_done();
        check_page("restart_final_d0", 8'hD0, 0, 159);

        // New commit coinciding with the last-byte write.
        cpu_write(DMA_REG, 8'hC0);
        clear_counts();
        repeat (4 + 636) @(negedge clk);
        cpu_write(DMA_REG, 8'hC1);
        #1;
        check("boundary_pulses", 64'(oam_pulses), 64'd160);
        check("boundary_last_byte", {56'd0, oam[159]}, {56'd0, mem_byte(16'hC09F)});
        check("boundary_setup_state", {62'd0, dbg_state}, 64'd1);
        check_setup_and_first(8'hC1);
        wait_done();
        check_page("boundary_c1_page", 8'hC1, 0, 159);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
